// File: rtl/instr_fetch_decode.sv
// Instruction memory, branch LUT and run-control FSM for a small sequencer.
// Decode is combinational from ProgCtr; Done and InstrCnt are registered.
//
// state | meaning
// IDLE  | after reset, waiting for Start
// ARM   | Start held high, counter parked at address 0
// RUN   | fetching/decoding one instruction per cycle
// HALT  | halt opcode retired, results held until next Start
module instr_fetch_decode #(
    parameter int L  = 10,
    parameter int W  = 8,
    parameter int IW = 9
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [L-1:0]  ProgCtr,
    input  logic          LoadEn,
    input  logic [L-1:0]  LoadAddr,
    input  logic [IW-1:0] LoadData,
    input  logic          LutWe,
    input  logic [3:0]    LutAddr,
    input  logic [W-1:0]  LutData,
    output logic [3:0]    Opcode,
    output logic [4:0]    Operand,
    output logic          BOE,
    output logic [W-1:0]  Target,
    output logic          Done,
    output logic          Busy,
    output logic [15:0]   InstrCnt
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, HALT} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_mem [2**L];
    logic [W-1:0]  r_lut [16];
    logic [15:0]   r_cnt;
    logic          r_done;
    logic [IW-1:0] w_instr;
    logic          w_run;
    logic          w_wr_ok;
    logic          w_boe;

    assign w_instr = r_mem[ProgCtr];
    assign w_run   = (r_state == RUN);
    assign w_wr_ok = !Reset && !w_run;

    // Instruction memory deliberately has no reset so a program survives Reset.
    always_ff @(posedge Clk) begin
        if (LoadEn && w_wr_ok)
            r_mem[LoadAddr] <= LoadData;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 16; i++)
                r_lut[i] <= '0;
        end else if (LutWe && !w_run) begin
            r_lut[LutAddr] <= LutData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Start in RUN is an abort and wins over a halt opcode in the same cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (Start) w_next = ARM;
            ARM:  if (!Start) w_next = RUN;
            RUN: begin
                if (Start)
                    w_next = ARM;
                else if (w_instr[8:5] == 4'hF)
                    w_next = HALT;
            end
            HALT: if (Start) w_next = ARM;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (w_next == HALT);
            if (w_next == ARM)
                r_cnt <= '0;
            else if (w_run && (r_cnt != 16'hFFFF))
                r_cnt <= r_cnt + 16'd1;
        end
    end

    assign w_boe = w_run && (w_instr[8:5] == 4'hE);

    always_comb begin
        Opcode  = '0;
        Operand = '0;
        Target  = '0;
        if (w_run) begin
            Opcode  = w_instr[8:5];
            Operand = w_instr[4:0];
        end
        if (w_boe)
            Target = r_lut[w_instr[3:0]];
    end

    assign BOE      = w_boe;
    assign Done     = r_done;
    assign Busy     = w_run;
    assign InstrCnt = r_cnt;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Randomized and directed bench for instr_fetch_decode against a cycle-level
// reference model of the sequencer's rules.
module tb_instr_fetch_decode;

    localparam int S_IDLE = 0, S_ARM = 1, S_RUN = 2, S_HALT = 3;

    logic        Clk = 1'b0;
    logic        Reset, Start, LoadEn, LutWe;
    logic [9:0]  ProgCtr, LoadAddr;
    logic [8:0]  LoadData;
    logic [3:0]  LutAddr;
    logic [7:0]  LutData;
    logic [3:0]  Opcode;
    logic [4:0]  Operand;
    logic        BOE, Done, Busy;
    logic [7:0]  Target;
    logic [15:0] InstrCnt;

    int n_vec = 0;
    int n_err = 0;

    logic [8:0]  m_mem [1024];
    logic [7:0]  m_lut [16];
    int          m_st = S_IDLE;
    int          m_cnt = 0;
    logic        m_done = 1'b0;
    bit          m_valid = 1'b0;

    instr_fetch_decode dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ProgCtr(ProgCtr),
        .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData),
        .LutWe(LutWe), .LutAddr(LutAddr), .LutData(LutData),
        .Opcode(Opcode), .Operand(Operand), .BOE(BOE), .Target(Target),
        .Done(Done), .Busy(Busy), .InstrCnt(InstrCnt)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // One clock: check outputs against the model, then advance the model at the edge.
    task automatic cyc();
        logic [8:0] ins;
        bit         run;
        bit         e_boe;
        int         nxt;
        #1;
        ins   = m_mem[ProgCtr];
        run   = (m_st == S_RUN);
        e_boe = run && (ins[8:5] == 4'hE);
        if (m_valid) begin
            chk("opcode",  Opcode,   run ? ins[8:5] : 4'h0);
            chk("operand", Operand,  run ? ins[4:0] : 5'h0);
            chk("boe",     BOE,      e_boe);
            chk("target",  Target,   e_boe ? m_lut[ins[3:0]] : 8'h0);
            chk("busy",    Busy,     run);
            chk("done",    Done,     m_done);
            chk("instrcnt", InstrCnt, m_cnt);
        end
        @(posedge Clk);
        if (Reset) begin
            m_st = S_IDLE; m_cnt = 0; m_done = 1'b0; m_valid = 1'b1;
            for (int i = 0; i < 16; i++) m_lut[i] = 8'h0;
        end else begin
            nxt = m_st;
            case (m_st)
                S_IDLE: if (Start) nxt = S_ARM;
                S_ARM:  if (!Start) nxt = S_RUN;
                S_RUN:  if (Start) nxt = S_ARM; else if (ins[8:5] == 4'hF) nxt = S_HALT;
                default: if (Start) nxt = S_ARM;
            endcase
            if (nxt == S_ARM) m_cnt = 0;
            else if (run && m_cnt < 65535) m_cnt = m_cnt + 1;
            m_done = (nxt == S_HALT);
            if (!run) begin
                if (LoadEn) m_mem[LoadAddr] = LoadData;
                if (LutWe) m_lut[LutAddr] = LutData;
            end
            m_st = nxt;
        end
        @(negedge Clk);
    endtask

    task automatic load_mem(input logic [9:0] a, input logic [8:0] d);
        LoadEn = 1'b1; LoadAddr = a; LoadData = d;
        cyc();
        LoadEn = 1'b0;
    endtask

    task automatic load_lut(input logic [3:0] a, input logic [7:0] d);
        LutWe = 1'b1; LutAddr = a; LutData = d;
        cyc();
        LutWe = 1'b0;
    endtask

    // Start high for two cycles, then one low cycle at address 0: ends in RUN.
    task automatic launch();
        Start = 1'b1; ProgCtr = 10'd0;
        cyc(); cyc();
        Start = 1'b0;
        cyc();
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; ProgCtr = '0; LoadEn = 1'b0; LoadAddr = '0;
        LoadData = '0; LutWe = 1'b0; LutAddr = '0; LutData = '0;
        for (int i = 0; i < 1024; i++) m_mem[i] = 9'h0;
        for (int i = 0; i < 16; i++) m_lut[i] = 8'h0;
        @(negedge Clk);
        cyc(); cyc();
        Reset = 1'b0;
        #1;
        chk("rst_done", Done, 1'b0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_cnt", InstrCnt, 16'h0);
        @(negedge Clk);

        for (int i = 0; i < 1024; i++) load_mem(10'(i), 9'($urandom));

        load_mem(10'd0, 9'h000); load_mem(10'd1, 9'h1C3);
        load_mem(10'd2, 9'h0A0); load_mem(10'd3, 9'h1E0);
        load_mem(10'd5, 9'h045);
        load_lut(4'd3, 8'h02);

        launch();
        ProgCtr = 10'd1; #1;
        chk("r41_busy", Busy, 1'b1);
        chk("r41_boe", BOE, 1'b1);
        chk("r41_target", Target, 8'h02);
        cyc();
        ProgCtr = 10'd2; LoadEn = 1'b1; LoadAddr = 10'd5; LoadData = 9'h1E0;
        cyc();
        LoadEn = 1'b0; ProgCtr = 10'd3;
        cyc();
        #1;
        chk("r41_done", Done, 1'b1);
        chk("r41_cnt", InstrCnt, 16'd3);
        chk("r41_busy_halt", Busy, 1'b0);
        @(negedge Clk);

        load_mem(10'd5, 9'h1E0);
        Start = 1'b1; cyc();
        #1;
        chk("r43_done", Done, 1'b0);
        chk("r43_cnt", InstrCnt, 16'd0);
        chk("r43_busy", Busy, 1'b0);
        @(negedge Clk);
        Start = 1'b0; ProgCtr = 10'd0; cyc();
        ProgCtr = 10'd5; #1;
        chk("r43_run", Busy, 1'b1);
        chk("r44_opcode", Opcode, 4'hF);
        cyc();
        #1;
        chk("r44_done", Done, 1'b1);
        chk("r44_cnt", InstrCnt, 16'd1);
        @(negedge Clk);

        launch();
        ProgCtr = 10'd1; #1;
        chk("r45_boe_pre", BOE, 1'b1);
        Reset = 1'b1;
        cyc();
        Reset = 1'b0; #1;
        chk("r45_boe", BOE, 1'b0);
        chk("r45_busy", Busy, 1'b0);
        chk("r45_done", Done, 1'b0);
        @(negedge Clk);
        launch();
        ProgCtr = 10'd1; #1;
        chk("r45_boe_run", BOE, 1'b1);
        chk("r45_lut0", Target, 8'h00);
        cyc();
        ProgCtr = 10'd2; cyc();
        ProgCtr = 10'd3; cyc();
        #1;
        chk("r45_done_end", Done, 1'b1);
        chk("r45_cnt_end", InstrCnt, 16'd3);
        @(negedge Clk);

        for (int n = 0; n < 3000; n++) begin
            Reset    = ($urandom_range(0, 199) == 0);
            Start    = ($urandom_range(0, 9) == 0);
            ProgCtr  = 10'($urandom);
            LoadEn   = ($urandom_range(0, 3) == 0);
            LoadAddr = 10'($urandom);
            LoadData = 9'($urandom);
            LutWe    = ($urandom_range(0, 3) == 0);
            LutAddr  = 4'($urandom);
            LutData  = 8'($urandom);
            cyc();
        end
        Reset = 1'b1; Start = 1'b0; LoadEn = 1'b0; LutWe = 1'b0;
        cyc();
        Reset = 1'b0;

        load_mem(10'd7, 9'h000);
        launch();
        ProgCtr = 10'd7;
        for (int n = 0; n < 70000; n++) cyc();
        #1;
        chk("r42_cnt_sat", InstrCnt, 16'hFFFF);
        chk("r42_busy", Busy, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_decode.md
INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

Interface
REQ-001 Parameters SHALL be: L, 10, program-counter/instruction-address width; W, 8, branch-target width; IW, 9, instruction width.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  program-launch level, shared with the program counter.
REQ-005 ProgCtr  input  L  current instruction address from the program counter.
REQ-006 LoadEn  input  1  instruction-memory write strobe.
REQ-007 LoadAddr  input  L  instruction-memory write address.
REQ-008 LoadData  input  IW  instruction-memory write data.
REQ-009 LutWe  input  1  branch-LUT write strobe.
REQ-010 LutAddr  input  4  branch-LUT write index.
REQ-011 LutData  input  W  branch-LUT write data.
REQ-012 Opcode  output  4  Instr[8:5] of the current instruction; 0 when not RUN.
REQ-013 Operand  output  5  Instr[4:0] of the current instruction; 0 when not RUN.
REQ-014 BOE  output  1  branch-on-equal request to the program counter.
REQ-015 Target  output  W  branch target address.
REQ-016 Done  output  1  program halted.
REQ-017 Busy  output  1  high in RUN.
REQ-018 InstrCnt  output  16  count of instructions retired in the current run.

Function
REQ-019 Storage SHALL be: instruction memory of 2^L x IW, written on posedge when LoadEn=1; branch LUT of 16 x W, written on posedge when LutWe=1.
REQ-020 Memory and LUT writes SHALL be ignored while in RUN.
REQ-021 Instruction read SHALL be combinational: Instr = mem[ProgCtr], so BOE/Target are valid in the same cycle as ProgCtr and are sampled by the counter at the next edge.
REQ-022 FSM states SHALL be IDLE, ARM, RUN, HALT.
REQ-023 IDLE SHALL go to ARM when Start=1.
REQ-024 ARM SHALL hold while Start=1 and go to RUN on the first cycle with Start=0 (the cycle in which the counter leaves address 0).
REQ-025 RUN SHALL go to HALT when Opcode=4'hF; the halt instruction counts as retired.
REQ-026 HALT SHALL go to ARM when Start=1.
REQ-027 Start=1 in RUN SHALL abort to ARM, with InstrCnt cleared on that edge.
REQ-028 Branch decode SHALL, in RUN with Opcode=4'hE, drive BOE=1 and Target=LUT[Operand[3:0]].
REQ-029 Outside the branch case of REQ-028, BOE and Target SHALL be 0.
REQ-030 Opcode, Operand and BOE SHALL be forced to 0 in IDLE, ARM and HALT.
REQ-031 Done SHALL be 1 only in HALT and SHALL be registered: it asserts on the edge entering HALT and deasserts on the edge leaving it.
REQ-032 Busy SHALL equal (state==RUN).
REQ-033 InstrCnt SHALL clear on entry to ARM, increment by 1 per RUN cycle, and saturate at 16'hFFFF (no wrap).
REQ-034 InstrCnt SHALL hold in HALT until the next Start.
REQ-035 If LUT write and branch read hit the same index in the same cycle, the read SHALL return the old value (write is blocked in RUN anyway).
REQ-036 ProgCtr beyond the loaded program SHALL read whatever memory contains; no bounds checking.

Reset
REQ-037 Reset=1 at posedge SHALL set state=IDLE, Done=0, InstrCnt=0, and clear all LUT entries to 0.
REQ-038 Instruction memory SHALL NOT be cleared by Reset.
REQ-039 Reset SHALL take priority over Start, LoadEn and LutWe in the same cycle.
REQ-040 Reset asserted mid-RUN SHALL return the block to IDLE on the next edge, with BOE=0 combinationally from that edge.

Verification
REQ-041 Load mem[0..3]={9'h000,9'h1C3,9'h0A0,9'h1E0}, LUT[3]=8'h02; pulse Start 2 cycles -> RUN with ProgCtr=1, BOE=1, Target=8'h02 that cycle; halt at addr 3; Done=1; InstrCnt=3.
REQ-042 Program with no 4'hF for 70000 cycles -> InstrCnt=16'hFFFF held, Busy=1.
REQ-043 In HALT raise Start -> Done=0 next edge, InstrCnt=0, state ARM; Start low -> RUN.
REQ-044 LoadEn=1 to addr 5 with 9'h1E0 during RUN -> mem[5] unchanged; the same write in HALT succeeds.
REQ-045 Reset mid-RUN with BOE=1 -> next edge BOE=0, Busy=0, Done=0, LUT reads 0; a reloaded program runs correctly without reloading memory.
